// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths, opcodes that the fetch
// unit resolves locally, and the fetch sequencer state encoding.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int OPR_W   = 4;
  localparam int OPND_W  = 12;

  localparam logic [OPR_W-1:0] OP_JMP = 4'b0100;
  localparam logic [OPR_W-1:0] OP_JZ  = 4'b0101;
  localparam logic [OPR_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  // Opcode field of an instruction word.
  function automatic logic [OPR_W-1:0] instr_opr(input logic [INSTR_W-1:0] w);
    return w[INSTR_W-1 -: OPR_W];
  endfunction

  // Operand/address field of an instruction word.
  function automatic logic [OPND_W-1:0] instr_operand(input logic [INSTR_W-1:0] w);
    return w[OPND_W-1:0];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port: req/addr from the fetch unit, rvalid/rdata
// returned by the memory (rvalid may be asserted in the same cycle as req).
interface instr_fetch_if
  import cpu_pkg::*;
#(
  parameter int AW = 8
) ();

  logic               req;
  logic [AW-1:0]      addr;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  // Fetch unit side.
  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  // Memory side.
  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/instr_fetch_next_pc_calc.sv
// Combinational next-PC computation applied at the end of an issue window:
// JMP takes the operand, JZ takes it only when zero_flag is set, everything
// else advances by one with wrap-around at 2^AW.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [AW-1:0]      pc,
  input  logic [INSTR_W-1:0] ir,
  input  logic               zero_flag,
  output logic [AW-1:0]      next_pc
);

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] target;

  // Select between sequential and branch target; operand bits above AW are dropped.
  always_comb begin
    pc_inc = pc + AW'(1);
    target = AW'(instr_operand(ir));
    unique case (instr_opr(ir))
      OP_JMP:  next_pc = target;
      OP_JZ:   next_pc = zero_flag ? target : pc_inc;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: owns the PC, fetches words over the imem
// req/rvalid handshake, holds them in IR and presents opr/operand to the
// controller for EXEC_CYCLES cycles. JMP/JZ/HLT are resolved here, so the
// controller only ever sees halt=1 or a valid opcode.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int AW          = 8,
  parameter int EXEC_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  instr_fetch_if.master        imem,
  input  logic                 zero_flag,
  output logic [OPR_W-1:0]     opr,
  output logic [OPND_W-1:0]    operand,
  output logic                 halt,
  output logic [AW-1:0]        pc,
  output logic                 busy
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

  fetch_state_e       state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               halt_q, halt_d;
  logic               req_q, req_d;
  logic [AW-1:0]      next_pc;

  next_pc_calc #(
    .AW (AW)
  ) u_next_pc (
    .pc        (pc_q),
    .ir        (ir_q),
    .zero_flag (zero_flag),
    .next_pc   (next_pc)
  );

  // Next-state logic; halt/req are derived from the next state so that the
  // registered copies line up with the state they describe.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        if (imem.rvalid) begin
          ir_d    = imem.rdata;
          cnt_d   = '0;
          state_d = (instr_opr(imem.rdata) == OP_HLT) ? ST_HALTED : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    halt_d = (state_d != ST_ISSUE);
    req_d  = (state_d == ST_FETCH);
  end

  // Sequencer state, PC, IR, issue counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b1;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      req_q   <= req_d;
    end
  end

  assign imem.req  = req_q;
  assign imem.addr = pc_q;
  assign opr       = instr_opr(ir_q);
  assign operand   = instr_operand(ir_q);
  assign halt      = halt_q;
  assign pc        = pc_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_ISSUE);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed program walk plus a random
// program, checked against an instruction-level model of PC sequencing.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int AW   = 8;
  localparam int EXEC = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              zero_flag;
  logic [OPR_W-1:0]  opr;
  logic [OPND_W-1:0] operand;
  logic              halt;
  logic [AW-1:0]     pc;
  logic              busy;

  instr_fetch_if #(.AW(AW)) imem ();

  instr_fetch #(
    .AW          (AW),
    .EXEC_CYCLES (EXEC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem      (imem),
    .zero_flag (zero_flag),
    .opr       (opr),
    .operand   (operand),
    .halt      (halt),
    .pc        (pc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: program image, expected PC, whether the program halted.
  logic [15:0] mem [256];
  int          mpc;
  bit          mhalted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    mpc     = 0;
    mhalted = 0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem.req === 1'b1) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
    check("req_timeout", 32'(imem.req), 32'd1);
  endtask

  // One instruction: fetch with 'lat' idle cycles before rvalid, issue window
  // with zero_flag pattern zpat (bit i = issue cycle i), then PC update.
  task automatic run_instr(input int lat, input logic [7:0] zpat, input bit rnd_start);
    bit          ok;
    logic [15:0] w;
    wait_req(ok);
    if (!ok) return;
    check("fetch_addr", 32'(imem.addr), 32'(mpc));
    check("fetch_halt", 32'(halt), 32'd1);
    check("fetch_busy", 32'(busy), 32'd1);
    w = mem[mpc];
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("req_hold", 32'(imem.req), 32'd1);
    end
    imem.rvalid = 1'b1;
    imem.rdata  = w;
    start       = rnd_start ? 1'($urandom) : 1'b0;
    @(negedge clk);
    imem.rvalid = 1'b0;
    imem.rdata  = 16'($urandom);
    start       = 1'b0;
    if (w[15:12] == 4'hF) begin
      mhalted = 1;
      check("hlt_halt", 32'(halt), 32'd1);
      check("hlt_busy", 32'(busy), 32'd0);
      check("hlt_req",  32'(imem.req), 32'd0);
      check("hlt_pc",   32'(pc), 32'(mpc));
      imem.rvalid = 1'b1;
      @(negedge clk);
      imem.rvalid = 1'b0;
      check("hlt_stay_busy", 32'(busy), 32'd0);
      check("hlt_stay_halt", 32'(halt), 32'd1);
      check("hlt_ir",        32'({opr, operand}), 32'(w));
      return;
    end
    for (int i = 0; i < EXEC; i++) begin
      check("issue_opr",     32'(opr), 32'(w[15:12]));
      check("issue_operand", 32'(operand), 32'(w[11:0]));
      check("issue_halt",    32'(halt), 32'd0);
      check("issue_busy",    32'(busy), 32'd1);
      check("issue_req",     32'(imem.req), 32'd0);
      zero_flag = zpat[i];
      start     = rnd_start ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    zero_flag = 1'b0;
    start     = 1'b0;
    case (w[15:12])
      4'h4:    mpc = int'(w[7:0]);
      4'h5:    mpc = zpat[EXEC-1] ? int'(w[7:0]) : (mpc + 1) % 256;
      default: mpc = (mpc + 1) % 256;
    endcase
    check("next_pc",     32'(pc), 32'(mpc));
    check("window_end",  32'(halt), 32'd1);
  endtask

  initial begin
    bit ok;
    rst_n       = 1'b0;
    start       = 1'b0;
    zero_flag   = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    mpc         = 0;
    mhalted     = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    @(negedge clk);
    check("rst_halt",    32'(halt), 32'd1);
    check("rst_req",     32'(imem.req), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_pc",      32'(pc), 32'd0);
    check("rst_opr",     32'(opr), 32'd0);
    check("rst_operand", 32'(operand), 32'd0);
    rst_n = 1'b1;
    imem.rvalid = 1'b1;
    imem.rdata  = 16'h1234;
    @(negedge clk);
    imem.rvalid = 1'b0;
    check("idle_busy",   32'(busy), 32'd0);
    check("idle_ir",     32'({opr, operand}), 32'd0);

    // Directed program walk.
    mem[8'h00] = 16'h0123;
    mem[8'h01] = 16'h4055;
    mem[8'h55] = 16'h5010;
    mem[8'h10] = 16'h40FF;
    mem[8'hFF] = 16'h2000;
    do_start();
    run_instr(2, 8'h00, 0);
    run_instr(0, 8'h00, 0);
    run_instr(1, 8'b100, 0);
    run_instr(0, 8'h00, 0);
    run_instr(3, 8'h00, 0);
    run_instr(0, 8'h00, 0);
    run_instr(0, 8'h00, 0);
    mem[8'h56] = 16'hF000;
    run_instr(0, 8'b011, 0);
    run_instr(1, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halted_halt", 32'(halt), 32'd1);
      check("halted_pc",   32'(pc), 32'(mpc));
    end
    do_start();
    wait_req(ok);
    check("restart_addr", 32'(imem.addr), 32'd0);

    // Random program.
    for (int i = 0; i < 256; i++) begin
      int unsigned r;
      r = $urandom_range(99);
      if (r < 8)       mem[i] = {4'hF, 12'($urandom)};
      else if (r < 25) mem[i] = {4'h4, 12'($urandom)};
      else if (r < 45) mem[i] = {4'h5, 12'($urandom)};
      else begin
        logic [3:0] op;
        op = 4'($urandom_range(3));
        if (r % 2 == 0) op = 4'($urandom_range(6, 14));
        mem[i] = {op, 12'($urandom)};
      end
    end
    mem[0] = 16'h1000;
    for (int n = 0; n < 400; n++) begin
      if (mhalted) do_start();
      run_instr(int'($urandom_range(3)), 8'($urandom), 1);
    end

    // Reset during a fetch with rvalid pending.
    if (mhalted) do_start();
    wait_req(ok);
    imem.rvalid = 1'b1;
    imem.rdata  = 16'h7ABC;
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",  32'(imem.req), 32'd0);
    check("arst_halt", 32'(halt), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pc",   32'(pc), 32'd0);
    check("arst_ir",   32'({opr, operand}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem.rvalid = 1'b0;
    check("late_rvalid_ir",   32'({opr, operand}), 32'd0);
    check("late_rvalid_busy", 32'(busy), 32'd0);
    check("late_rvalid_req",  32'(imem.req), 32'd0);
    check("late_rvalid_halt", 32'(halt), 32'd1);

    do_start();
    run_instr(0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
